imem_uart_loader: RTL and testbench

Writes a program image into the instruction memory. Bytes come from the UART receiver as a byte-valid stream and are packed into words. The block drives the memory write port (address, data, write enable) and holds the CPU in reset while loading runs. It is the writer counterpart of the single-port instruction ROM/RAM read path: the core fetches the image later through the read-only port.

---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/loader_timeout_counter.sv | 34 +++
 rtl/imem_uart_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_uart_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Holds the FSM state encoding, frame-format constants and a counter-width helper.
// No logic of its own; imported by the loader top and its sub-module.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    DONE,
    ERROR
  } state_t;

  // Default image word width and the bytes it takes on the wire.
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

  // The length header is a 16-bit word count sent low byte first.
  localparam int LEN_BYTES = 2;

  // Width of a counter that indexes n byte lanes (at least 1 bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// Idle watchdog for the loader: counts consecutive enabled clocks without a clear.
// Latency: expired is combinational, high on the TIMEOUT_CYCLES-th idle clock.
// Backpressure: none; clear wins over enable, disabled counter sits at zero.
// Ports: clk, rst_n (async active-low), clear, enable in; expired out.
module loader_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of idle clocks already seen, so the clock that
  // observes cnt == TIMEOUT_CYCLES-1 is the TIMEOUT_CYCLES-th idle clock.
  assign expired = enable && !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !enable || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Packs a UART byte stream (16-bit word count, then LSB-first words) into imem writes.
// Latency: we pulses exactly one clock after the edge that accepts a word's last byte.
// Backpressure: none; bytes are accepted on every rx_valid, extra or stray bytes dropped.
// Ports: clk, rst_n, start, rx_valid, rx_data in; we, addr, wd (memory write port),
//        busy, cpu_hold, done, err (status), words_written (session word count) out.
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wd,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam int BPW      = DATA_WIDTH / 8;
  localparam int BCW      = cnt_width(BPW);
  localparam int AW1      = ADDR_WIDTH + 1;
  localparam int LEN_BITS = 8 * LEN_BYTES;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
  localparam logic [32:0]    MAX_WORDS = 33'(1) << ADDR_WIDTH;

  state_t state, state_nxt;

  logic [7:0]            len_lo;
  logic [ADDR_WIDTH:0]   len_q;
  logic [BCW-1:0]        byte_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] word_nxt;
  logic [LEN_BITS-1:0]   len_rx;
  logic                  len_zero;
  logic                  len_over;
  logic                  all_written;
  logic                  active;
  logic                  expired;
  logic                  tmo_clear;
  logic                  take_byte;

  assign len_rx   = {rx_data, len_lo};
  assign len_zero = (len_rx == '0);
  assign len_over = (33'(len_rx) > MAX_WORDS);

  // True only during the write cycle of the final word: DATA then drains to DONE
  // and any byte arriving in that cycle is surplus.
  assign all_written = (words_written == len_q);

  assign active    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign tmo_clear = start || rx_valid || !active;
  assign take_byte = (state == DATA) && rx_valid && !start && !all_written;

  loader_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmo_clear),
    .enable (active),
    .expired(expired)
  );

  // Current word with the incoming byte dropped into its lane.
  always_comb begin
    word_nxt = shreg;
    for (int i = 0; i < BPW; i++) begin
      if (byte_cnt == BCW'(i)) begin
        word_nxt[8*i +: 8] = rx_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        busy = 1'b1;
        if (start)         state_nxt = LEN_LO;
        else if (expired)  state_nxt = ERROR;
        else if (rx_valid) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        busy = 1'b1;
        if (start)         state_nxt = LEN_LO;
        else if (expired)  state_nxt = ERROR;
        else if (rx_valid) begin
          if (len_zero)      state_nxt = DONE;
          else if (len_over) state_nxt = ERROR;
          else               state_nxt = DATA;
        end
      end
      DATA: begin
        busy = 1'b1;
        if (start)            state_nxt = LEN_LO;
        else if (all_written) state_nxt = DONE;
        else if (expired)     state_nxt = ERROR;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = LEN_LO;
      end
      ERROR: begin
        err = 1'b1;
        if (start) state_nxt = LEN_LO;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_hold = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we            <= 1'b0;
      addr          <= '0;
      wd            <= '0;
      words_written <= '0;
      len_lo        <= '0;
      len_q         <= '0;
      byte_cnt      <= '0;
      shreg         <= '0;
    end else begin
      we <= 1'b0;
      if (start) begin
        // New session: drop any partial word and restart the word count.
        byte_cnt      <= '0;
        words_written <= '0;
      end else begin
        if ((state == LEN_LO) && rx_valid) len_lo <= rx_data;
        if ((state == LEN_HI) && rx_valid) len_q  <= AW1'(len_rx);
        if (take_byte) begin
          shreg <= word_nxt;
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt      <= '0;
            we            <= 1'b1;
            wd            <= word_nxt;
            addr          <= words_written[ADDR_WIDTH-1:0];
            words_written <= words_written + 1'b1;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: directed frames plus randomized images.
// Writes are captured on the memory port and scored against an expected write list.
// Ports: none (top-level bench).
module tb_imem_uart_loader;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wd;
  logic          busy;
  logic          cpu_hold;
  logic          done;
  logic          err;
  logic [AW:0]   words_written;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
    int          ww;
  } wr_t;

  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [31:0] img[$];

  imem_uart_loader #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .we           (we),
    .addr         (addr),
    .wd           (wd),
    .busy         (busy),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle the write port is enabled becomes one recorded write.
  always @(negedge clk) begin
    if (we === 1'b1) got_q.push_back('{cyc, int'(addr), wd, int'(words_written)});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All driving tasks are entered and left on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_cyc"},  64'(got_q[i].cyc),  64'(exp_q[i].cyc));
      chk({tag, "_addr"}, 64'(got_q[i].addr), 64'(exp_q[i].addr));
      chk({tag, "_data"}, 64'(got_q[i].data), 64'(exp_q[i].data));
      chk({tag, "_ww"},   64'(got_q[i].ww),   64'(exp_q[i].ww));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Send the frame for img; each completed word is expected on the port in the
  // cycle right after its last byte, at address j, with words_written = j+1.
  task automatic do_load(input string tag, input int maxgap, input bit with_start);
    logic [15:0] n;
    logic [31:0] w;
    n = 16'(img.size());
    if (with_start) begin
      pulse_start();
      chk({tag, "_busy0"}, 64'(busy), 64'(1));
      chk({tag, "_hold0"}, 64'(cpu_hold), 64'(1));
      chk({tag, "_ww0"},   64'(words_written), 64'(0));
    end
    idle($urandom_range(0, maxgap));
    send_byte(n[7:0]);
    idle($urandom_range(0, maxgap));
    send_byte(n[15:8]);
    for (int j = 0; j < img.size(); j++) begin
      w = img[j];
      for (int b = 0; b < 4; b++) begin
        idle($urandom_range(0, maxgap));
        send_byte(w[8*b +: 8]);
      end
      exp_q.push_back('{cyc, j, w, j + 1});
    end
    idle(1);
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_hold"}, 64'(cpu_hold), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_err"},  64'(err), 64'(0));
    chk({tag, "_ww"},   64'(words_written), 64'(img.size()));
    compare_writes(tag);
  endtask

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1 rst_n = 1'b0;
    idle(3);

    chk("rst_we",   64'(we), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_wd",   64'(wd), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_hold", 64'(cpu_hold), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err",  64'(err), 64'(0));
    chk("rst_ww",   64'(words_written), 64'(0));
    rst_n = 1'b1;
    idle(2);

    // Stray bytes in IDLE do nothing.
    send_byte(8'h01);
    send_byte(8'h00);
    idle(2);
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_nwr",  64'(got_q.size()), 64'(0));

    // Normal load, all bytes back-to-back (word 1 byte 0 lands in word 0's write cycle).
    img.delete();
    img.push_back(32'h0000_0013);
    img.push_back(32'h0010_0093);
    do_load("normal", 0, 1'b1);

    // Zero length: DONE right after the second header byte.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    chk("zero_done", 64'(done), 64'(1));
    chk("zero_hold", 64'(cpu_hold), 64'(0));
    chk("zero_ww",   64'(words_written), 64'(0));
    idle(2);
    chk("zero_nwr",  64'(got_q.size()), 64'(0));

    // Exactly 2**AW words is legal; one more is rejected.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h04);
    chk("over_err",  64'(err), 64'(1));
    chk("over_hold", 64'(cpu_hold), 64'(0));
    chk("over_done", 64'(done), 64'(0));
    send_byte(8'h11);
    send_byte(8'h22);
    idle(2);
    chk("over_err_hold", 64'(err), 64'(1));
    chk("over_nwr",      64'(got_q.size()), 64'(0));
    pulse_start();
    chk("over_clr_err",  64'(err), 64'(0));
    chk("over_clr_busy", 64'(busy), 64'(1));

    pulse_start();
    send_byte(8'h00);
    send_byte(8'h04);
    chk("max_len_err",  64'(err), 64'(0));
    chk("max_len_busy", 64'(busy), 64'(1));

    // Timeout: one clock short is still fine, the next one errors.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    idle(TMO - 1);
    chk("tmo_early_err",  64'(err), 64'(0));
    chk("tmo_early_busy", 64'(busy), 64'(1));
    idle(1);
    chk("tmo_err",  64'(err), 64'(1));
    chk("tmo_hold", 64'(cpu_hold), 64'(0));
    chk("tmo_ww",   64'(words_written), 64'(0));
    chk("tmo_nwr",  64'(got_q.size()), 64'(0));

    // Timeout after one committed word keeps the count.
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h99);
    idle(TMO);
    chk("tmo2_err",  64'(err), 64'(1));
    chk("tmo2_ww",   64'(words_written), 64'(1));
    chk("tmo2_nwr",  64'(got_q.size()), 64'(1));
    if (got_q.size() > 0) chk("tmo2_data", 64'(got_q[0].data), 64'h1234_5678);
    got_q.delete();

    // Restart mid-DATA with a colliding byte: byte dropped, session back at LEN_LO.
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h44);
    send_byte(8'h33);
    send_byte(8'h22);
    send_byte(8'h11);
    send_byte(8'hEE);
    send_byte(8'hDD);
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
    chk("rs_busy", 64'(busy), 64'(1));
    chk("rs_ww",   64'(words_written), 64'(0));
    chk("rs_nwr",  64'(got_q.size()), 64'(1));
    if (got_q.size() > 0) chk("rs_data", 64'(got_q[0].data), 64'h1122_3344);
    got_q.delete();
    img.delete();
    img.push_back($urandom);
    img.push_back($urandom);
    do_load("rs_load", 2, 1'b0);

    // Asynchronous reset during the write cycle of a word.
    pulse_start();
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we",   64'(we), 64'(0));
    chk("arst_addr", 64'(addr), 64'(0));
    chk("arst_wd",   64'(wd), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_hold", 64'(cpu_hold), 64'(0));
    chk("arst_ww",   64'(words_written), 64'(0));
    got_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h01);
    send_byte(8'h00);
    idle(2);
    chk("arst_idle_busy", 64'(busy), 64'(0));
    chk("arst_idle_nwr",  64'(got_q.size()), 64'(0));

    // Randomized images with random inter-byte gaps.
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(1, 6);
      img.delete();
      for (int k = 0; k < n; k++) img.push_back($urandom);
      do_load("rand", $urandom_range(0, 4), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
